// File: rtl/axis_operand_joiner_pkg.sv
// Shared types and helpers for the adder-tile operand joiner: flit field split and queued operand format.
package noc_adder_pkg;

    localparam int TDATAW = 32;
    localparam int SRCW   = 4;
    localparam int OPW    = TDATAW - SRCW;

    localparam logic [SRCW-1:0] SRC_A_ID_DEFAULT = 4'd0;
    localparam logic [SRCW-1:0] SRC_B_ID_DEFAULT = 4'd2;

    typedef struct packed {
        logic           last;
        logic [OPW-1:0] op;
    } operand_t;

    function automatic logic [SRCW-1:0] get_tag(input logic [TDATAW-1:0] tdata);
        return tdata[TDATAW-1 -: SRCW];
    endfunction

    function automatic logic [OPW-1:0] get_op(input logic [TDATAW-1:0] tdata);
        return tdata[OPW-1:0];
    endfunction

endpackage

// File: rtl/axis_operand_joiner_if.sv
// AXI-stream handshake bundle; one instance for the mesh flit side, one for the pair side.
interface axis_operand_joiner_if #(
    parameter int W = 32
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;
    logic         tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_operand_joiner_fifo.sv
// Synchronous FIFO with extra wrap bit on the pointers; the head entry is visible without a pop.
module joiner_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // full is evaluated on the pointers before this cycle's pop, so a pop never frees a slot early
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // storage write
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axis_operand_joiner.sv
// Demuxes mesh flits by source tag into per-operand FIFOs and emits aligned {B,A} pairs on a registered AXIS output.
module axis_operand_joiner
    import noc_adder_pkg::*;
#(
    parameter logic [SRCW-1:0] SRC_A_ID = SRC_A_ID_DEFAULT,
    parameter logic [SRCW-1:0] SRC_B_ID = SRC_B_ID_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter int              CNTW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    axis_operand_joiner_if.slave  s_axis,
    axis_operand_joiner_if.master m_axis,
    output logic [CNTW-1:0]     pair_count,
    output logic                err_src,
    output logic                err_last
);
    localparam logic [CNTW-1:0]  CNT_MAX   = {CNTW{1'b1}};
    localparam logic [CNTW-1:0]  CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [2*OPW-1:0] PAIR_ZERO = {(2*OPW){1'b0}};

    logic [SRCW-1:0]  tag_s;
    operand_t         in_opnd_s;
    operand_t         head_a_s;
    operand_t         head_b_s;
    logic             is_a_s;
    logic             is_b_s;
    logic             full_a_s;
    logic             full_b_s;
    logic             empty_a_s;
    logic             empty_b_s;
    logic             tready_s;
    logic             s_hs_s;
    logic             push_a_s;
    logic             push_b_s;
    logic             drop_s;
    logic             pop_s;
    logic             m_hs_s;

    logic             m_tvalid_r;
    logic [2*OPW-1:0] m_tdata_r;
    logic             m_tlast_r;
    logic [CNTW-1:0]  pair_count_r;
    logic             err_src_r;
    logic             err_last_r;

    assign tag_s  = get_tag(s_axis.tdata);
    assign is_a_s = (tag_s == SRC_A_ID);
    assign is_b_s = (tag_s == SRC_B_ID);

    // ingress field split into the queued operand format
    always_comb begin
        in_opnd_s      = '0;
        in_opnd_s.last = s_axis.tlast;
        in_opnd_s.op   = get_op(s_axis.tdata);
    end

    // ready depends only on the tag's own FIFO, so a stalled A stream never blocks B flits
    always_comb begin
        tready_s = 1'b0;
        if (rst) begin
            tready_s = 1'b0;
        end else if (is_a_s) begin
            tready_s = !full_a_s;
        end else if (is_b_s) begin
            tready_s = !full_b_s;
        end else begin
            tready_s = 1'b1;
        end
    end

    assign s_axis.tready = tready_s;
    assign s_hs_s        = s_axis.tvalid && tready_s;
    assign push_a_s      = s_hs_s && is_a_s;
    assign push_b_s      = s_hs_s && is_b_s;
    assign drop_s        = s_hs_s && !is_a_s && !is_b_s;

    assign m_hs_s = m_tvalid_r && m_axis.tready;
    assign pop_s  = !empty_a_s && !empty_b_s && (!m_tvalid_r || m_axis.tready);

    joiner_fifo #(.WIDTH($bits(operand_t)), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a_s),
        .wdata (in_opnd_s),
        .pop   (pop_s),
        .head  (head_a_s),
        .full  (full_a_s),
        .empty (empty_a_s)
    );

    joiner_fifo #(.WIDTH($bits(operand_t)), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b_s),
        .wdata (in_opnd_s),
        .pop   (pop_s),
        .head  (head_b_s),
        .full  (full_b_s),
        .empty (empty_b_s)
    );

    // output pair register; data only changes on a pop, so it holds under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= PAIR_ZERO;
            m_tlast_r  <= 1'b0;
        end else if (pop_s) begin
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= {head_b_s.op, head_a_s.op};
            m_tlast_r  <= head_a_s.last && head_b_s.last;
        end else if (m_hs_s) begin
            m_tvalid_r <= 1'b0;
        end
    end

    // saturating count of delivered pairs
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_count_r <= {CNTW{1'b0}};
        end else if (m_hs_s && (pair_count_r != CNT_MAX)) begin
            pair_count_r <= pair_count_r + CNT_ONE;
        end
    end

    // sticky protocol error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_src_r  <= 1'b0;
            err_last_r <= 1'b0;
        end else begin
            if (drop_s) begin
                err_src_r <= 1'b1;
            end
            if (pop_s && (head_a_s.last != head_b_s.last)) begin
                err_last_r <= 1'b1;
            end
        end
    end

    assign m_axis.tvalid = m_tvalid_r;
    assign m_axis.tdata  = m_tdata_r;
    assign m_axis.tlast  = m_tlast_r;
    assign pair_count    = pair_count_r;
    assign err_src       = err_src_r;
    assign err_last      = err_last_r;

endmodule

// File: tb/tb_axis_operand_joiner.sv
// Self-checking bench: flits are pushed into a queue-based pairing model and observed pairs are compared in order.
module tb_axis_operand_joiner;

    localparam int CNTW   = 5;
    localparam int CNTMAX = 31;

    logic clk;
    logic rst;
    logic [CNTW-1:0] pair_count;
    logic err_src;
    logic err_last;

    axis_operand_joiner_if #(.W(32)) s_if ();
    axis_operand_joiner_if #(.W(56)) m_if ();

    axis_operand_joiner #(
        .SRC_A_ID (4'd0),
        .SRC_B_ID (4'd2),
        .DEPTH    (4),
        .CNTW     (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .pair_count (pair_count),
        .err_src    (err_src),
        .err_last   (err_last)
    );

    int total = 0;
    int bad   = 0;

    logic [28:0] a_q[$];
    logic [28:0] b_q[$];
    logic [56:0] exp_q[$];
    logic [56:0] obs_q[$];
    bit exp_err_src;
    bit exp_err_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && m_if.tvalid && m_if.tready) obs_q.push_back({m_if.tlast, m_if.tdata});
    end

    function automatic void model_clear();
        a_q.delete(); b_q.delete(); exp_q.delete(); obs_q.delete();
        exp_err_src = 1'b0; exp_err_last = 1'b0;
    endfunction

    // pairing rule: i-th A flit joins i-th B flit, {B,A}, last = both lasts
    function automatic void model_push(input logic [3:0] tag, input logic [27:0] op, input bit last);
        logic [28:0] fa, fb;
        if (tag == 4'd0) a_q.push_back({last, op});
        else if (tag == 4'd2) b_q.push_back({last, op});
        else exp_err_src = 1'b1;
        while (a_q.size() > 0 && b_q.size() > 0) begin
            fa = a_q.pop_front();
            fb = b_q.pop_front();
            exp_q.push_back({fa[28] & fb[28], fb[27:0], fa[27:0]});
            if (fa[28] != fb[28]) exp_err_last = 1'b1;
        end
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic send_flit(input logic [3:0] tag, input logic [27:0] op, input bit last);
        int waited = 0;
        bit done = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = {tag, op};
        s_if.tlast  = last;
        while (!done && waited < 300) begin
            @(negedge clk);
            if (s_if.tready) begin
                done = 1;
                @(posedge clk); #1;
            end else begin
                waited++;
            end
        end
        s_if.tvalid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL send_accept tag=%0d op=%0d ready_seen=0 want=1", tag, op);
        end else begin
            model_push(tag, op, last);
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while (obs_q.size() < exp_q.size() && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = {4'd0, 28'd9};
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", s_if.tready); end
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b want=0", m_if.tvalid); end
        total++; if (m_if.tdata !== 56'd0 || m_if.tlast !== 1'b0) begin bad++; $display("FAIL rst_mdata got=%h/%b want=0/0", m_if.tdata, m_if.tlast); end
        total++; if (pair_count !== 5'd0 || err_src !== 1'b0 || err_last !== 1'b0) begin
            bad++; $display("FAIL rst_status got=%0d/%b/%b want=0/0/0", pair_count, err_src, err_last);
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_in_order();
        do_reset();
        m_if.tready = 1'b1;
        send_flit(4'd0, 28'd5, 1'b0);
        send_flit(4'd2, 28'd7, 1'b0);
        total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", m_if.tvalid); end
        @(posedge clk); #1;
        total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== {28'd7, 28'd5}) begin
            bad++; $display("FAIL lat_pair got=%b/%h want=1/%h", m_if.tvalid, m_if.tdata, {28'd7, 28'd5});
        end
        wait_drain();
        total++; if (pair_count !== 5'd1) begin bad++; $display("FAIL inorder_count got=%0d want=1", pair_count); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL inorder_npairs got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_fill();
        do_reset();
        m_if.tready = 1'b1;
        for (int i = 1; i <= 4; i++) send_flit(4'd0, 28'(i), 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = {4'd0, 28'd5};
        @(negedge clk);
        total++; if (s_if.tready !== 1'b0) begin bad++; $display("FAIL fill_a_blocked got=%b want=0", s_if.tready); end
        s_if.tvalid = 1'b0;
        s_if.tdata  = {4'd2, 28'd10};
        #1;
        total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL fill_b_flows got=%b want=1", s_if.tready); end
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) send_flit(4'd2, 28'(10 * i), 1'b0);
        wait_drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL fill_npairs got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL fill_pair%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        total++; if (obs_q.size() > 0 && obs_q[0] !== {1'b0, 28'd10, 28'd1}) begin bad++; $display("FAIL fill_first got=%h want=%h", obs_q[0], {1'b0, 28'd10, 28'd1}); end
    endtask

    task automatic test_bad_tag();
        do_reset();
        m_if.tready = 1'b1;
        send_flit(4'd5, 28'd99, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (err_src !== 1'b1) begin bad++; $display("FAIL badtag_err got=%b want=1", err_src); end
        total++; if (obs_q.size() != 0 || m_if.tvalid !== 1'b0) begin bad++; $display("FAIL badtag_nopair got=%0d want=0", obs_q.size()); end
        send_flit(4'd0, 28'd3, 1'b0);
        send_flit(4'd2, 28'd4, 1'b0);
        wait_drain();
        total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL badtag_pair n=%0d want n=1 pair=%h", obs_q.size(), exp_q[0]); end
        total++; if (err_src !== 1'b1 || err_last !== 1'b0) begin bad++; $display("FAIL badtag_flags got=%b/%b want=1/0", err_src, err_last); end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_if.tready = 1'b0;
        for (int i = 1; i <= 3; i++) send_flit(4'd0, 28'(i), 1'b0);
        for (int i = 1; i <= 3; i++) send_flit(4'd2, 28'(10 + i), i == 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_q[0][55:0]) begin
                bad++; $display("FAIL bp_hold c%0d got=%b/%h want=1/%h", c, m_if.tvalid, m_if.tdata, exp_q[0][55:0]);
            end
        end
        @(posedge clk); #1;
        m_if.tready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL bp_b2b c%0d got=%b want=1", c, m_if.tvalid); end
        end
        wait_drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_npairs got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_pair%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_last_and_reset();
        do_reset();
        m_if.tready = 1'b1;
        send_flit(4'd0, 28'd6, 1'b1);
        send_flit(4'd2, 28'd8, 1'b0);
        wait_drain();
        total++; if (err_last !== exp_err_last) begin bad++; $display("FAIL last_err got=%b want=%b", err_last, exp_err_last); end
        total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL last_pair n=%0d want=%h", obs_q.size(), exp_q[0]); end
        m_if.tready = 1'b0;
        send_flit(4'd0, 28'd1, 1'b0);
        send_flit(4'd0, 28'd2, 1'b0);
        send_flit(4'd2, 28'd3, 1'b0);
        do_reset();
        total++; if (m_if.tvalid !== 1'b0 || pair_count !== 5'd0 || err_last !== 1'b0) begin
            bad++; $display("FAIL midrst_state got=%b/%0d/%b want=0/0/0", m_if.tvalid, pair_count, err_last);
        end
        m_if.tready = 1'b1;
        send_flit(4'd2, 28'd50, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_stale got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        send_flit(4'd0, 28'd60, 1'b1);
        wait_drain();
        total++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL midrst_pair n=%0d want=%h", obs_q.size(), exp_q[0]); end
    endtask

    task automatic test_random();
        bit done = 0;
        int na = 0, nb = 0;
        int exp_cnt;
        do_reset();
        fork
            begin
                for (int k = 0; k < 160; k++) begin
                    logic [3:0] tag;
                    if ($urandom_range(0, 19) == 0) tag = 4'($urandom_range(3, 15));
                    else if (na - nb >= 3) tag = 4'd2;
                    else if (nb - na >= 3) tag = 4'd0;
                    else tag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd2;
                    if (tag == 4'd0) na++;
                    if (tag == 4'd2) nb++;
                    send_flit(tag, 28'($urandom), bit'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 1)) @(posedge clk);
                    #1;
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_if.tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_if.tready = 1'b1;
        wait_drain();
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_npairs got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_pair%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        exp_cnt = (exp_q.size() > CNTMAX) ? CNTMAX : exp_q.size();
        total++; if (pair_count !== exp_cnt[CNTW-1:0]) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", pair_count, exp_cnt); end
        total++; if (err_src !== exp_err_src || err_last !== exp_err_last) begin
            bad++; $display("FAIL rnd_flags got=%b/%b want=%b/%b", err_src, err_last, exp_err_src, exp_err_last);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = 32'd0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        model_clear();
        test_reset();
        test_in_order();
        test_fill();
        test_bad_tag();
        test_backpressure();
        test_last_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
